cpu_lsu_align: RTL

Load/store alignment unit between the memory stage and the data cache. The data cache only handles 32-bit word accesses, so this block turns byte, halfword and word loads and stores into word-aligned cache transactions. Loads get lane extraction and sign or zero extension. Sub-word stores become a read-modify-write sequence. It holds the memory stage's request/ready handshake and drives the data cache's request/ready port.

---
 rtl/cpu_lsu_align.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_lsu_align.sv
// Purpose : load/store alignment between memory stage and a word-only data cache.
// Latency : load / word store = cache latency + 1; sub-word store = read + 1 gap + write + 1.
// Backpress: one access in flight; o_ready held until i_request drops; waits on i_dc_ready.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_request/o_ready         memory-stage handshake (o_ready = i_request && DONE)
//   i_rw, i_address, i_width, i_signed, i_wdata   access operands (latched on accept)
//   o_rdata, o_fault          registered load result and misalignment flag
//   o_dc_*/i_dc_*             word-aligned data cache request/ready port
//
// Optional feature macro: CPU_LSU_FAULT_EN (misaligned half/word accesses fault
// instead of being silently aligned down).
module cpu_lsu_align (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [31:0] i_address,
   input  logic [1:0]  i_width,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   output logic        o_ready,
   output logic [31:0] o_rdata,
   output logic        o_fault,
   output logic        o_dc_rw,
   output logic        o_dc_request,
   input  logic        i_dc_ready,
   output logic [31:0] o_dc_address,
   input  logic [31:0] i_dc_rdata,
   output logic [31:0] o_dc_wdata
);

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_GAP, WR, DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_addr, w_addr_nxt;       // byte lane of the accepted access
   logic [1:0]  r_width, w_width_nxt;
   logic        r_signed, w_signed_nxt;
   logic [15:0] r_wdata, w_wdata_nxt;     // only sub-word stores need it later
   logic [31:0] w_rdata_nxt;
   logic        w_fault_nxt;
   logic        w_dc_rw_nxt;
   logic        w_dc_request_nxt;
   logic [31:0] w_dc_address_nxt;
   logic [31:0] w_dc_wdata_nxt;

   // Request-side decode (raw inputs, used only in IDLE).
   logic       w_in_half;
   logic       w_in_word;
   logic [1:0] w_addr_lo;
   logic       w_misaligned;

   assign w_in_half = (i_width == 2'd1);
   assign w_in_word = i_width[1];          // width 3 behaves as word

   // Halves ignore addr[0] and words ignore addr[1:0]; in the fault build the
   // misaligned cases never reach the cache, so the forcing is harmless there.
   assign w_addr_lo = w_in_word ? 2'b00 :
                      w_in_half ? {i_address[1], 1'b0} : i_address[1:0];

`ifdef CPU_LSU_FAULT_EN
   assign w_misaligned = (w_in_half && i_address[0]) || (w_in_word && (i_address[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   // Lane handling on latched operands.
   logic        w_is_byte;
   logic        w_is_half;
   logic [4:0]  w_shamt;
   logic [31:0] w_lane;
   logic [31:0] w_load_ext;
   logic [31:0] w_mask;
   logic [31:0] w_merge;

   assign w_is_byte = (r_width == 2'd0);
   assign w_is_half = (r_width == 2'd1);
   assign w_shamt   = w_is_byte ? {r_addr, 3'b000} :
                      w_is_half ? {r_addr[1], 4'b0000} : 5'd0;
   assign w_lane    = i_dc_rdata >> w_shamt;

   always_comb begin
      w_load_ext = i_dc_rdata;
      if (w_is_byte)
         w_load_ext = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      else if (w_is_half)
         w_load_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
   end

   // Store merge: replace only the addressed lane(s) of the word just read.
   assign w_mask  = (w_is_byte ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
   assign w_merge = (i_dc_rdata & ~w_mask) | (({16'h0000, r_wdata} << w_shamt) & w_mask);

   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_width_nxt      = r_width;
      w_signed_nxt     = r_signed;
      w_wdata_nxt      = r_wdata;
      w_rdata_nxt      = o_rdata;
      w_fault_nxt      = o_fault;
      w_dc_rw_nxt      = o_dc_rw;
      w_dc_request_nxt = o_dc_request;
      w_dc_address_nxt = o_dc_address;
      w_dc_wdata_nxt   = o_dc_wdata;
      case (r_state)
         IDLE: begin
            if (i_request) begin
               w_addr_nxt   = w_addr_lo;
               w_width_nxt  = i_width;
               w_signed_nxt = i_signed;
               w_wdata_nxt  = i_wdata[15:0];
               w_fault_nxt  = 1'b0;
               if (w_misaligned) begin
                  w_fault_nxt = 1'b1;
                  w_rdata_nxt = 32'h0;
                  w_state_nxt = DONE;
               end else begin
                  w_dc_address_nxt = {i_address[31:2], 2'b00};
                  w_dc_request_nxt = 1'b1;
                  if (!i_rw) begin
                     w_dc_rw_nxt = 1'b0;
                     w_state_nxt = RD;
                  end else if (w_in_word) begin
                     w_dc_rw_nxt    = 1'b1;
                     w_dc_wdata_nxt = i_wdata;
                     w_state_nxt    = WR;
                  end else begin
                     w_dc_rw_nxt = 1'b0;
                     w_state_nxt = RMW_RD;
                  end
               end
            end
         end
         RD: begin
            if (i_dc_ready) begin
               w_rdata_nxt      = w_load_ext;
               w_dc_request_nxt = 1'b0;
               w_state_nxt      = DONE;
            end
         end
         RMW_RD: begin
            if (i_dc_ready) begin
               w_dc_wdata_nxt   = w_merge;
               w_dc_request_nxt = 1'b0;
               w_state_nxt      = RMW_GAP;
            end
         end
         RMW_GAP: begin
            // One idle cycle lets the cache drop its level-style ready.
            w_dc_rw_nxt      = 1'b1;
            w_dc_request_nxt = 1'b1;
            w_state_nxt      = WR;
         end
         WR: begin
            if (i_dc_ready) begin
               w_dc_request_nxt = 1'b0;
               w_dc_rw_nxt      = 1'b0;
               w_state_nxt      = DONE;
            end
         end
         DONE: begin
            if (!i_request)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_addr       <= 2'b00;
         r_width      <= 2'b00;
         r_signed     <= 1'b0;
         r_wdata      <= 16'h0;
         o_rdata      <= 32'h0;
         o_fault      <= 1'b0;
         o_dc_rw      <= 1'b0;
         o_dc_request <= 1'b0;
         o_dc_address <= 32'h0;
         o_dc_wdata   <= 32'h0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_width      <= w_width_nxt;
         r_signed     <= w_signed_nxt;
         r_wdata      <= w_wdata_nxt;
         o_rdata      <= w_rdata_nxt;
         o_fault      <= w_fault_nxt;
         o_dc_rw      <= w_dc_rw_nxt;
         o_dc_request <= w_dc_request_nxt;
         o_dc_address <= w_dc_address_nxt;
         o_dc_wdata   <= w_dc_wdata_nxt;
      end
   end

   assign o_ready = i_request && (r_state == DONE);

endmodule
